// File: rtl/fp_mul_scheduler.sv
// Round-robin issue scheduler sharing one fixed-latency pipelined FP multiplier between two requesters.
// Optional performance counters are enabled with `define FP_MUL_SCHED_PERF_EN.
module fp_mul_scheduler #(
    parameter int MUL_LAT = 4,
    parameter int TAG_W   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [31:0]      mul_result,
    input  logic             hold,
    input  logic             flush,
    output logic             busy
`ifdef FP_MUL_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_issue_cnt,
    output logic [31:0]      perf_conflict_cnt
`endif
);

    logic                        issue_en;
    logic                        grant0;
    logic                        grant1;
    logic                        issue;
    logic                        prio_q;
    logic                        prio_d;
    logic [MUL_LAT-1:0]          vld_q;
    logic [MUL_LAT-1:0]          vld_d;
    logic [MUL_LAT-1:0]          id_q;
    logic [MUL_LAT-1:0]          id_d;
    logic [MUL_LAT-1:0][TAG_W-1:0] tag_q;
    logic [MUL_LAT-1:0][TAG_W-1:0] tag_d;
    logic                        tail_vld;

    // Readies are forced low while reset is asserted so nothing looks accepted.
    always_comb begin
        issue_en = reset_n & ~hold & ~flush;
        grant0   = issue_en & req0_valid & (~req1_valid | ~prio_q);
        grant1   = issue_en & req1_valid & (~req0_valid | prio_q);
        issue    = grant0 | grant1;
        prio_d   = issue ? grant0 : prio_q;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        mul_a = 32'h0;
        mul_b = 32'h0;
        if (grant0) begin
            mul_a = req0_a;
            mul_b = req0_b;
        end else if (grant1) begin
            mul_a = req1_a;
            mul_b = req1_b;
        end
    end

    assign vld_d[0] = issue;
    assign id_d[0]  = grant1;
    assign tag_d[0] = grant1 ? req1_tag : (grant0 ? req0_tag : '0);

    // Tracker stages mirror the multiplier pipeline; flush drops every valid bit.
    generate
        for (genvar gi = 1; gi < MUL_LAT; gi++) begin : g_stage
            assign vld_d[gi] = vld_q[gi-1] & ~flush;
            assign id_d[gi]  = id_q[gi-1];
            assign tag_d[gi] = tag_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            id_q   <= '0;
            tag_q  <= '0;
            prio_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            id_q   <= id_d;
            tag_q  <= tag_d;
            prio_q <= prio_d;
        end
    end

    assign tail_vld   = vld_q[MUL_LAT-1] & ~flush;
    assign rsp0_valid = tail_vld & ~id_q[MUL_LAT-1];
    assign rsp1_valid = tail_vld & id_q[MUL_LAT-1];
    assign rsp_data   = tail_vld ? mul_result : 32'h0;
    assign rsp_tag    = tail_vld ? tag_q[MUL_LAT-1] : '0;
    assign busy       = |vld_q;

`ifdef FP_MUL_SCHED_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_conflict_q;
    logic        conflict;

    assign conflict = req0_valid & req1_valid & issue;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_issue_q    <= 32'h0;
            perf_conflict_q <= 32'h0;
        end else begin
            if (issue) begin
                perf_issue_q <= perf_issue_q + 32'd1;
            end
            if (conflict) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt    = perf_issue_q;
    assign perf_conflict_cnt = perf_conflict_q;
`else
    // Without counters the scheduler behaves identically; no extra state exists.
`endif

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Randomized self-checking bench for fp_mul_scheduler against a cycle-indexed return schedule model.
module tb_fp_mul_scheduler;
    localparam int L  = 4;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [31:0]   req0_a, req0_b, req1_a, req1_b;
    logic [TW-1:0] req0_tag, req1_tag;
    logic          rsp0_valid, rsp1_valid;
    logic [31:0]   rsp_data;
    logic [TW-1:0] rsp_tag;
    logic [31:0]   mul_a, mul_b, mul_result;
    logic          hold, flush, busy;
`ifdef FP_MUL_SCHED_PERF_EN
    logic [31:0]   perf_issue_cnt, perf_conflict_cnt;
`endif

    always #5 clk = ~clk;

    fp_mul_scheduler #(.MUL_LAT(L), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .hold(hold), .flush(flush), .busy(busy)
`ifdef FP_MUL_SCHED_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    // Truncating single-precision multiply, valid for normal operands with in-range results.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] ma, mb, p;
        logic [22:0] m;
        int          e;
        ma = {25'd0, 1'b1, a[22:0]};
        mb = {25'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    // Behavioural multiplier: fixed L-cycle delay from operands to product.
    logic [31:0] mp [L];
    always @(posedge clk) begin
        mp[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end
    assign mul_result = mp[L-1];

    // Model: what returns in which cycle, indexed by absolute cycle number.
    bit          s_v    [0:4095];
    bit          s_id   [0:4095];
    logic [2:0]  s_tag  [0:4095];
    logic [31:0] s_data [0:4095];
    bit          m_prio;
    int          m_issue, m_conf;
    int          cyc;
    int          n_checks, n_fail;
    bit          gg0, gg1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4096; k++) s_v[k] = 1'b0;
        m_prio  = 1'b0;
        m_issue = 0;
        m_conf  = 0;
    endtask

    task automatic do_cycle(input bit v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] t0,
                            input bit v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] t1,
                            input bit h, input bit f, output bit g0, output bit g1);
        bit          rv, eb;
        logic [31:0] ea, ebv;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_tag = t0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_tag = t1;
        hold = h; flush = f;
        #1;
        g0  = !h && !f && v0 && (!v1 || !m_prio);
        g1  = !h && !f && v1 && (!v0 || m_prio);
        ea  = g0 ? a0 : (g1 ? a1 : 32'h0);
        ebv = g0 ? b0 : (g1 ? b1 : 32'h0);
        rv  = s_v[cyc] && !f;
        eb  = 1'b0;
        for (int k = 0; k < L; k++) eb |= s_v[cyc+k];
        check_val("req0_ready", 32'(req0_ready), 32'(g0));
        check_val("req1_ready", 32'(req1_ready), 32'(g1));
        check_val("mul_a", mul_a, ea);
        check_val("mul_b", mul_b, ebv);
        check_val("rsp0_valid", 32'(rsp0_valid), 32'(rv && !s_id[cyc]));
        check_val("rsp1_valid", 32'(rsp1_valid), 32'(rv && s_id[cyc]));
        check_val("rsp_data", rsp_data, rv ? s_data[cyc] : 32'h0);
        check_val("rsp_tag", 32'(rsp_tag), rv ? 32'(s_tag[cyc]) : 32'h0);
        check_val("busy", 32'(busy), 32'(eb));
`ifdef FP_MUL_SCHED_PERF_EN
        check_val("perf_issue", perf_issue_cnt, 32'(m_issue));
        check_val("perf_conflict", perf_conflict_cnt, 32'(m_conf));
`endif
        if (f) begin
            for (int k = 0; k <= L; k++) s_v[cyc+k] = 1'b0;
        end
        if (g0 || g1) begin
            s_v[cyc+L]    = 1'b1;
            s_id[cyc+L]   = g1;
            s_tag[cyc+L]  = g1 ? t1 : t0;
            s_data[cyc+L] = g1 ? fmul(a1, b1) : fmul(a0, b0);
            m_prio        = g0;
            m_issue++;
            if (v0 && v1) m_conf++;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        bit x0, x1;
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x0, x1);
    endtask

    // Reset asserted between edges with both requesters valid: outputs must drop at once.
    task automatic do_async_reset();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; hold = 1'b0; flush = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_rsp0", 32'(rsp0_valid), 32'h0);
        check_val("rst_rsp1", 32'(rsp1_valid), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_rdy0", 32'(req0_ready), 32'h0);
        check_val("rst_rdy1", 32'(req1_ready), 32'h0);
        check_val("rst_mul_a", mul_a, 32'h0);
        check_val("rst_rsp_data", rsp_data, 32'h0);
`ifdef FP_MUL_SCHED_PERF_EN
        check_val("rst_perf_issue", perf_issue_cnt, 32'h0);
`endif
        model_clear();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        bit          pv [2];
        logic [31:0] pa [2];
        logic [31:0] pb [2];
        logic [2:0]  pt [2];
        bit          h, f;
        n_checks = 0; n_fail = 0; cyc = 0;
        reset_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_tag = 0; req1_tag = 0; hold = 0; flush = 0;
        model_clear();
        @(negedge clk);
        do_async_reset();

        // Contention straight after reset: grants alternate starting with requester 0.
        for (int r = 0; r < 2; r++) begin
            pa[r] = rand_fp(); pb[r] = rand_fp(); pt[r] = 3'($urandom);
        end
        for (int i = 0; i < 6; i++) begin
            do_cycle(1, pa[0], pb[0], pt[0], 1, pa[1], pb[1], pt[1], 0, 0, gg0, gg1);
            check_val("contention_grant0", 32'(gg0), 32'((i % 2) == 0));
            if (gg0) begin pa[0] = rand_fp(); pb[0] = rand_fp(); pt[0] = 3'($urandom); end
            if (gg1) begin pa[1] = rand_fp(); pb[1] = rand_fp(); pt[1] = 3'($urandom); end
        end
        idle(L + 1);

        // Single issue 2.0 * 3.0, tag 5.
        do_cycle(1, 32'h40000000, 32'h40400000, 3'd5, 0, 0, 0, 0, 0, 0, gg0, gg1);
        idle(L - 1);
        @(negedge clk); #1;
        check_val("single_rsp_data", rsp_data, 32'h40C00000);
        check_val("single_rsp_tag", 32'(rsp_tag), 32'd5);
        @(posedge clk); cyc++;
        idle(L);

        // Back-to-back requester 1, tags 0..7.
        for (int i = 0; i < 8; i++)
            do_cycle(0, 0, 0, 0, 1, rand_fp(), rand_fp(), 3'(i), 0, 0, gg0, gg1);
        idle(L + 1);

        // Two issues, then hold for three cycles with req0 still valid.
        for (int i = 0; i < 2; i++)
            do_cycle(1, rand_fp(), rand_fp(), 3'(i), 0, 0, 0, 0, 0, 0, gg0, gg1);
        pa[0] = rand_fp(); pb[0] = rand_fp();
        for (int i = 0; i < 3; i++)
            do_cycle(1, pa[0], pb[0], 3'd6, 0, 0, 0, 0, 1, 0, gg0, gg1);
        do_cycle(1, pa[0], pb[0], 3'd6, 0, 0, 0, 0, 0, 0, gg0, gg1);
        idle(L + 1);

        // Three issues, flush two cycles after the last.
        for (int i = 0; i < 3; i++)
            do_cycle(i != 1, rand_fp(), rand_fp(), 3'(i), i == 1, rand_fp(), rand_fp(), 3'(i + 3), 0, 0, gg0, gg1);
        idle(1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, gg0, gg1);
        idle(L + 1);

        // Reset mid-flight, then contention must grant requester 0 first.
        for (int i = 0; i < 2; i++)
            do_cycle(1, rand_fp(), rand_fp(), 3'(i), 0, 0, 0, 0, 0, 0, gg0, gg1);
        idle(1);
        do_async_reset();
        pa[0] = rand_fp(); pb[0] = rand_fp(); pa[1] = rand_fp(); pb[1] = rand_fp();
        do_cycle(1, pa[0], pb[0], 3'd1, 1, pa[1], pb[1], 3'd2, 0, 0, gg0, gg1);
        check_val("post_reset_grant0", 32'(gg0), 32'd1);
        do_cycle(0, 0, 0, 0, 1, pa[1], pb[1], 3'd2, 0, 0, gg0, gg1);
        idle(L + 1);

        // Random traffic obeying the valid/operand hold rule.
        pv[0] = 0; pv[1] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && ($urandom_range(0, 3) != 0)) begin
                    pv[r] = 1; pa[r] = rand_fp(); pb[r] = rand_fp(); pt[r] = 3'($urandom);
                end
            end
            h = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 15) == 0);
            do_cycle(pv[0], pa[0], pb[0], pt[0], pv[1], pa[1], pb[1], pt[1], h, f, gg0, gg1);
            if (gg0) pv[0] = 0;
            if (gg1) pv[1] = 0;
        end
        idle(L + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
